// File: rtl/period_measure_if.sv
// Measurement port bundle for period_measure: the asynchronous input, controls and results.
// The block drives the slave modport; the environment drives the master modport.
interface period_measure_if #(
  parameter int unsigned WIDTH = 32
);
  logic             SigIn;
  logic             Enable;
  logic [WIDTH-1:0] Timeout;
  logic [WIDTH-1:0] Period;
  logic [WIDTH-1:0] HighTime;
  logic             Valid;
  logic             Stalled;

  modport master (
    output SigIn,
    output Enable,
    output Timeout,
    input  Period,
    input  HighTime,
    input  Valid,
    input  Stalled
  );

  modport slave (
    input  SigIn,
    input  Enable,
    input  Timeout,
    output Period,
    output HighTime,
    output Valid,
    output Stalled
  );
endinterface

// File: rtl/period_measure.sv
// Measures the period and high time of an asynchronous square wave in ClkIn cycles,
// with a stall timeout and a saturating counter.
module period_measure #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ClkIn,
  input  logic             RstN,
  period_measure_if.slave  bus_io
);

  localparam int unsigned PrimeCycles = SYNC_STAGES + 1;
  localparam int unsigned PrimeW      = $clog2(PrimeCycles + 1);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [PrimeW-1:0]      prime_q, prime_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       hightime_q, hightime_d;
  logic                   valid_q, valid_d;
  logic                   stalled_q, stalled_d;

  logic             primed;
  logic             sync_msb;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt_inc;
  logic             timeout_hit;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus_io.SigIn};
  assign sync_msb = sync_q[SYNC_STAGES-1];

  // Edges stay masked until the synchronizer and history flop hold real samples,
  // so a level already high at reset release is not mistaken for a rise.
  assign primed  = (prime_q == PrimeW'(PrimeCycles));
  assign prime_d = primed ? prime_q : prime_q + PrimeW'(1);
  assign rise    = primed & sync_msb & ~hist_q;
  assign fall    = primed & ~sync_msb & hist_q;

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
  assign timeout_hit = (bus_io.Timeout != '0) && (cnt_q == bus_io.Timeout);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    period_d   = period_q;
    hightime_d = hightime_q;
    valid_d    = 1'b0;
    stalled_d  = stalled_q;

    if (!bus_io.Enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (rise) begin
            state_d   = StMeasure;
            cnt_d     = WIDTH'(1);
            high_d    = '0;
            stalled_d = 1'b0;
          end
        end
        StMeasure: begin
          // A rise in the same cycle as the timeout match is a normal update.
          if (rise) begin
            period_d   = cnt_q;
            hightime_d = high_q;
            valid_d    = 1'b1;
            cnt_d      = WIDTH'(1);
          end else if (timeout_hit) begin
            stalled_d = 1'b1;
            state_d   = StIdle;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              high_d = cnt_q;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      prime_q    <= '0;
      cnt_q      <= '0;
      high_q     <= '0;
      period_q   <= '0;
      hightime_q <= '0;
      valid_q    <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= sync_msb;
      prime_q    <= prime_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      period_q   <= period_d;
      hightime_q <= hightime_d;
      valid_q    <= valid_d;
      stalled_q  <= stalled_d;
    end
  end

  assign bus_io.Period   = period_q;
  assign bus_io.HighTime = hightime_q;
  assign bus_io.Valid    = valid_q;
  assign bus_io.Stalled  = stalled_q;

endmodule

// File: tb/tb_period_measure.sv
// Directed bench for period_measure: a 32-bit instance with timeout and an 8-bit instance with
// the timeout disabled share SigIn/Enable/RstN; Valid pulses are tallied by a monitor.
module tb_period_measure;

  logic ClkIn = 1'b0;
  logic RstN;

  period_measure_if #(.WIDTH(32)) bus ();
  period_measure_if #(.WIDTH(8))  bus8 ();

  period_measure #(.WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .ClkIn  (ClkIn),
    .RstN   (RstN),
    .bus_io (bus)
  );

  period_measure #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .ClkIn  (ClkIn),
    .RstN   (RstN),
    .bus_io (bus8)
  );

  always #5 ClkIn = ~ClkIn;

  int          total = 0;
  int          bad   = 0;
  int          vcnt  = 0;
  int          v0;
  logic [31:0] last_p = '0;
  logic [31:0] last_h = '0;

  always @(negedge ClkIn) begin
    if (bus.Valid) begin
      vcnt   <= vcnt + 1;
      last_p <= bus.Period;
      last_h <= bus.HighTime;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ClkIn);
    #1;
  endtask

  task automatic drive(input logic s);
    bus.SigIn  = s;
    bus8.SigIn = s;
  endtask

  task automatic set_en(input logic e);
    bus.Enable  = e;
    bus8.Enable = e;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < p; i++) begin
        drive(i < h);
        step();
      end
    end
  endtask

  initial begin
    RstN         = 1'b0;
    bus.Timeout  = 32'd1000;
    bus8.Timeout = 8'd0;
    drive(1'b0);
    set_en(1'b1);
    repeat (3) step();

    check("rst_period", bus.Period, 0);
    check("rst_high", bus.HighTime, 0);
    check("rst_valid", {31'd0, bus.Valid}, 0);
    check("rst_stalled", {31'd0, bus.Stalled}, 0);
    check("rst_period8", {24'd0, bus8.Period}, 0);
    check("rst_stalled8", {31'd0, bus8.Stalled}, 0);

    RstN = 1'b1;
    repeat (6) step();

    // Steady 10/5: first rise only arms the session.
    v0 = vcnt;
    wave(10, 5, 6);
    check("t1_valids", vcnt - v0, 5);
    check("t1_period", last_p, 10);
    check("t1_high", last_h, 5);
    check("t1_stalled", {31'd0, bus.Stalled}, 0);

    // 10/3 then 24/12; the first rise of each new pattern closes the previous period.
    v0 = vcnt;
    wave(10, 3, 4);
    check("t2a_valids", vcnt - v0, 4);
    check("t2a_period", last_p, 10);
    check("t2a_high", last_h, 3);
    v0 = vcnt;
    wave(24, 12, 2);
    check("t2b_valids", vcnt - v0, 2);
    check("t2b_period", last_p, 24);
    check("t2b_high", last_h, 12);

    // Stall: last rise is 10 iterations before the hold; Stalled appears once Cnt hits 50.
    wave(10, 5, 3);
    bus.Timeout = 32'd50;
    v0 = vcnt;
    drive(1'b0);
    repeat (42) step();
    check("t3_not_yet", {31'd0, bus.Stalled}, 0);
    step();
    check("t3_stalled", {31'd0, bus.Stalled}, 1);
    repeat (5) step();
    check("t3_stall_hold", {31'd0, bus.Stalled}, 1);
    check("t3_no_valid", vcnt - v0, 0);
    check("t3_period_hold", bus.Period, 10);
    v0 = vcnt;
    wave(10, 5, 1);
    check("t3_stall_clr", {31'd0, bus.Stalled}, 0);
    check("t3_first_rise", vcnt - v0, 0);
    wave(10, 5, 2);
    check("t3_resume", vcnt - v0, 2);
    check("t3_res_period", last_p, 10);
    check("t3_res_high", last_h, 5);
    bus.Timeout = 32'd1000;

    // Enable dropped for 3 cycles inside a 12-cycle period.
    v0 = vcnt;
    wave(10, 5, 1);
    wave(12, 4, 2);
    for (int i = 0; i < 12; i++) begin
      drive(i < 4);
      set_en(!(i >= 5 && i <= 7));
      step();
    end
    set_en(1'b1);
    check("t4_pre_valids", vcnt - v0, 4);
    check("t4_pre_period", last_p, 12);
    check("t4_pre_high", last_h, 4);
    v0 = vcnt;
    wave(10, 5, 1);
    check("t4_rearm", vcnt - v0, 0);
    check("t4_period_hold", bus.Period, 12);
    wave(10, 5, 2);
    check("t4_valids", vcnt - v0, 2);
    check("t4_period", last_p, 10);
    check("t4_high", last_h, 5);

    // Reset mid-period with SigIn high at release.
    drive(1'b1);
    step();
    step();
    RstN = 1'b0;
    #1;
    check("t5_period", bus.Period, 0);
    check("t5_high", bus.HighTime, 0);
    check("t5_valid", {31'd0, bus.Valid}, 0);
    check("t5_stalled", {31'd0, bus.Stalled}, 0);
    check("t5_period8", {24'd0, bus8.Period}, 0);
    step();
    step();
    RstN = 1'b1;
    repeat (8) step();
    drive(1'b0);
    repeat (5) step();
    v0 = vcnt;
    wave(10, 5, 1);
    check("t5_no_valid", vcnt - v0, 0);
    check("t5_period_zero", bus.Period, 0);
    wave(10, 5, 2);
    check("t5_valids", vcnt - v0, 2);
    check("t5_res_period", last_p, 10);
    check("t5_res_high", last_h, 5);

    // Long 300/150 period: the 8-bit instance saturates, the 32-bit one does not.
    v0 = vcnt;
    wave(300, 150, 3);
    check("t6_valids", vcnt - v0, 3);
    check("t6_period", bus.Period, 300);
    check("t6_high", bus.HighTime, 150);
    check("t6_period8", {24'd0, bus8.Period}, 255);
    check("t6_high8", {24'd0, bus8.HighTime}, 150);
    check("t6_stalled8", {31'd0, bus8.Stalled}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
